// File: rtl/oem_dac_ctrl.sv
// Output-memory write scheduler: packs the serial bit stream into bytes, spreads them
// over eight memories in a checkerboard pattern and zero-fills the remainder at end of frame.
module oem_dac_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       so_data,
    input  logic       so_valid,
    input  logic       pi_end,
    output logic [7:0] oem_dataout,
    output logic [4:0] oem_addr,
    output logic       odd1_wr,
    output logic       odd2_wr,
    output logic       odd3_wr,
    output logic       odd4_wr,
    output logic       even1_wr,
    output logic       even2_wr,
    output logic       even3_wr,
    output logic       even4_wr,
    output logic       oem_finish
);

    typedef enum logic [1:0] {COLLECT, FILL, DONE} state_t;

    state_t      state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bitcnt_q;
    logic [8:0]  n_q;
    logic        end_seen_q;
    logic        vld_prev_q;
    logic [7:0]  dataout_q;
    logic [4:0]  addr_q;
    logic [7:0]  wr_q;
    logic        finish_q;

    logic [7:0]  shift_d;
    logic [7:0]  pad_d;
    logic        fill_go_d;

    // Strobe index: bit 2 = even bank, bits 1:0 = memory number - 1.
    function automatic logic [7:0] strobe_for(input logic [7:0] idx);
        return 8'd1 << {idx[0] ^ idx[3], idx[7:6]};
    endfunction

    assign shift_d   = {shift_q[6:0], so_data};
    assign pad_d     = shift_q << (4'd8 - {1'b0, bitcnt_q});
    assign fill_go_d = (state_q == COLLECT) && vld_prev_q && !so_valid
                       && (end_seen_q || pi_end);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= COLLECT;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            n_q        <= '0;
            end_seen_q <= 1'b0;
            vld_prev_q <= 1'b0;
            dataout_q  <= '0;
            addr_q     <= '0;
            wr_q       <= '0;
            finish_q   <= 1'b0;
        end else begin
            wr_q       <= '0;
            vld_prev_q <= so_valid;
            case (state_q)
                COLLECT: begin
                    if (fill_go_d) begin
                        shift_q  <= '0;
                        bitcnt_q <= '0;
                        if (n_q[8]) begin
                            state_q  <= DONE;
                            finish_q <= 1'b1;
                        end else begin
                            // First fill write carries any partial byte, LSBs padded with zero.
                            wr_q      <= strobe_for(n_q[7:0]);
                            addr_q    <= n_q[5:1];
                            dataout_q <= (bitcnt_q != 3'd0) ? pad_d : 8'h00;
                            n_q       <= n_q + 9'd1;
                            state_q   <= FILL;
                        end
                    end else begin
                        if (pi_end) begin
                            end_seen_q <= 1'b1;
                        end
                        if (so_valid) begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7 && !n_q[8]) begin
                                wr_q      <= strobe_for(n_q[7:0]);
                                addr_q    <= n_q[5:1];
                                dataout_q <= shift_d;
                                n_q       <= n_q + 9'd1;
                            end
                        end
                    end
                end
                FILL: begin
                    if (n_q[8]) begin
                        state_q  <= DONE;
                        finish_q <= 1'b1;
                    end else begin
                        wr_q      <= strobe_for(n_q[7:0]);
                        addr_q    <= n_q[5:1];
                        dataout_q <= 8'h00;
                        n_q       <= n_q + 9'd1;
                    end
                end
                DONE: begin
                    finish_q <= 1'b1;
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign oem_dataout = dataout_q;
    assign oem_addr    = addr_q;
    assign odd1_wr     = wr_q[0];
    assign odd2_wr     = wr_q[1];
    assign odd3_wr     = wr_q[2];
    assign odd4_wr     = wr_q[3];
    assign even1_wr    = wr_q[4];
    assign even2_wr    = wr_q[5];
    assign even3_wr    = wr_q[6];
    assign even4_wr    = wr_q[7];
    assign oem_finish  = finish_q;

endmodule

// File: tb/tb_oem_dac_ctrl.sv
// Directed bench for oem_dac_ctrl: reset, byte packing, memory mapping, zero-fill,
// partial-byte padding and reset during fill.
module tb_oem_dac_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       so_data = 1'b0;
    logic       so_valid = 1'b0;
    logic       pi_end = 1'b0;
    logic [7:0] oem_dataout;
    logic [4:0] oem_addr;
    logic       odd1_wr, odd2_wr, odd3_wr, odd4_wr;
    logic       even1_wr, even2_wr, even3_wr, even4_wr;
    logic       oem_finish;

    oem_dac_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .so_data    (so_data),
        .so_valid   (so_valid),
        .pi_end     (pi_end),
        .oem_dataout(oem_dataout),
        .oem_addr   (oem_addr),
        .odd1_wr    (odd1_wr),
        .odd2_wr    (odd2_wr),
        .odd3_wr    (odd3_wr),
        .odd4_wr    (odd4_wr),
        .even1_wr   (even1_wr),
        .even2_wr   (even2_wr),
        .even3_wr   (even3_wr),
        .even4_wr   (even4_wr),
        .oem_finish (oem_finish)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] strb;
    assign strb = {even4_wr, even3_wr, even2_wr, even1_wr, odd4_wr, odd3_wr, odd2_wr, odd1_wr};

    // Write monitor: logs every strobe with its decoded slot and cycle number.
    int         cyc = 0;
    int         wr_cnt = 0;
    int         multi_hot = 0;
    int         fin_cyc = -1;
    logic       fin_prev = 1'b0;
    logic [7:0] log_data [0:1023];
    logic [7:0] log_slot [0:1023];
    int         log_cyc  [0:1023];

    function automatic logic [2:0] slot_of(input logic [7:0] s);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (s[i]) r = 3'(i);
        return r;
    endfunction

    // Expected slot: {even bank, memory-1, address}
    function automatic logic [7:0] exp_slot(input int k);
        logic [7:0] n;
        n = 8'(k);
        return {n[0] ^ n[3], n[7:6], n[5:1]};
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if ($countones(strb) > 1) multi_hot = multi_hot + 1;
        if (strb != 8'h00) begin
            if (wr_cnt < 1024) begin
                log_data[wr_cnt] = oem_dataout;
                log_slot[wr_cnt] = {slot_of(strb), oem_addr};
                log_cyc[wr_cnt]  = cyc;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (oem_finish && !fin_prev) fin_cyc = cyc;
        fin_prev = oem_finish;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; so_valid = 1'b0; so_data = 1'b0; pi_end = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_end);
        for (int i = 7; i >= 0; i--) begin
            so_valid = 1'b1;
            so_data  = b[i];
            pi_end   = (i == 7) && with_end;
            tick();
        end
        pi_end = 1'b0;
    endtask

    task automatic wait_finish(input int bound);
        int k;
        k = 0;
        while (!oem_finish && k < bound) begin
            tick();
            k++;
        end
        checks++;
        if (oem_finish !== 1'b1) begin
            errors++;
            $display("FAIL finish_timeout: oem_finish=%b after %0d cycles, required 1", oem_finish, k);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            so_valid = 1'($urandom_range(1));
            so_data  = 1'($urandom_range(1));
            pi_end   = 1'($urandom_range(1));
            tick();
            checks++;
            if ({strb, oem_addr, oem_dataout, oem_finish} !== 22'd0) begin
                errors++;
                $display("FAIL reset_outputs: strb=%h addr=%h data=%h fin=%b, required all 0",
                         strb, oem_addr, oem_dataout, oem_finish);
            end
        end
        reset = 1'b1; so_valid = 1'b0; so_data = 1'b0; pi_end = 1'b0;
        tick();
        checks++;
        if ({strb, oem_finish} !== 9'd0) begin
            errors++;
            $display("FAIL reset_release: strb=%h fin=%b, required 0", strb, oem_finish);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        apply_reset();
        send_byte(8'hA5, 1'b0);
        checks++;
        if (strb !== 8'h01 || oem_addr !== 5'd0 || oem_dataout !== 8'hA5) begin
            errors++;
            $display("FAIL single_A5: strb=%h addr=%0d data=%h, required 01 0 a5", strb, oem_addr, oem_dataout);
        end
        // Second byte with a one-cycle gap in the middle of the word.
        b = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) begin
                so_valid = 1'b0;
                tick();
            end
            so_valid = 1'b1;
            so_data  = b[i];
            tick();
        end
        checks++;
        if (strb !== 8'h10 || oem_addr !== 5'd0 || oem_dataout !== 8'h3C) begin
            errors++;
            $display("FAIL single_3C: strb=%h addr=%0d data=%h, required 10 0 3c", strb, oem_addr, oem_dataout);
        end
        so_valid = 1'b0;
        tick();
        checks++;
        if (strb !== 8'h00 || oem_addr !== 5'd0 || oem_dataout !== 8'h3C) begin
            errors++;
            $display("FAIL single_hold: strb=%h addr=%0d data=%h, required 00 0 3c", strb, oem_addr, oem_dataout);
        end
    endtask

    task automatic test_mapping();
        int base;
        apply_reset();
        base = wr_cnt;
        for (int n = 0; n < 256; n++) begin
            send_byte(8'(n), 1'b0);
            if (n == 8) begin
                checks++;
                if (strb !== 8'h10 || oem_addr !== 5'd4) begin
                    errors++;
                    $display("FAIL map_n8: strb=%h addr=%0d, required 10 4", strb, oem_addr);
                end
            end
            if (n == 9) begin
                checks++;
                if (strb !== 8'h01 || oem_addr !== 5'd4) begin
                    errors++;
                    $display("FAIL map_n9: strb=%h addr=%0d, required 01 4", strb, oem_addr);
                end
            end
            if (n == 64) begin
                checks++;
                if (strb !== 8'h02 || oem_addr !== 5'd0) begin
                    errors++;
                    $display("FAIL map_n64: strb=%h addr=%0d, required 02 0", strb, oem_addr);
                end
            end
            if (n == 255) begin
                checks++;
                if (strb !== 8'h08 || oem_addr !== 5'd31 || oem_dataout !== 8'hFF || oem_finish !== 1'b0) begin
                    errors++;
                    $display("FAIL map_n255: strb=%h addr=%0d data=%h fin=%b, required 08 31 ff 0",
                             strb, oem_addr, oem_dataout, oem_finish);
                end
            end
        end
        // Overflow byte with end marker: shifted in but never written.
        send_byte(8'hEE, 1'b1);
        checks++;
        if (strb !== 8'h00 || wr_cnt - base !== 256 || oem_finish !== 1'b0) begin
            errors++;
            $display("FAIL map_overflow: strb=%h writes=%0d fin=%b, required 00 256 0",
                     strb, wr_cnt - base, oem_finish);
        end
        so_valid = 1'b0;
        tick();
        checks++;
        if (oem_finish !== 1'b1 || strb !== 8'h00) begin
            errors++;
            $display("FAIL map_finish: fin=%b strb=%h, required 1 00", oem_finish, strb);
        end
        tick(); tick();
        checks++;
        if (oem_finish !== 1'b1 || wr_cnt - base !== 256) begin
            errors++;
            $display("FAIL map_no_fill: fin=%b writes=%0d, required 1 256", oem_finish, wr_cnt - base);
        end
    endtask

    task automatic check_fill(input string name, input int base, input logic [7:0] d0, input logic [7:0] d1);
        int bad;
        checks++;
        if (wr_cnt - base !== 256) begin
            errors++;
            $display("FAIL %s_count: writes=%0d, required 256", name, wr_cnt - base);
        end
        checks++;
        if (log_data[base] !== d0 || log_data[base+1] !== d1 || log_slot[base] !== 8'h00 || log_slot[base+1] !== 8'h80) begin
            errors++;
            $display("FAIL %s_head: data=%h,%h slot=%h,%h, required %h,%h 00,80", name,
                     log_data[base], log_data[base+1], log_slot[base], log_slot[base+1], d0, d1);
        end
        bad = 0;
        for (int k = 2; k < 256; k++) begin
            if (log_data[base+k] !== 8'h00 || log_slot[base+k] !== exp_slot(k) ||
                log_cyc[base+k] !== log_cyc[base+k-1] + 1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s_zero_fill: %0d bad fill writes, required 0", name, bad);
        end
        checks++;
        if (log_slot[base+255] !== 8'h7F || fin_cyc !== log_cyc[base+255] + 1) begin
            errors++;
            $display("FAIL %s_finish_timing: last slot=%h fin_cyc=%0d last_wr_cyc=%0d, required 7f and +1",
                     name, log_slot[base+255], fin_cyc, log_cyc[base+255]);
        end
    endtask

    task automatic test_zero_fill();
        int base;
        apply_reset();
        base = wr_cnt;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        so_valid = 1'b0;
        tick();
        wait_finish(400);
        check_fill("zfill", base, 8'h12, 8'h34);
        for (int i = 0; i < 3; i++) begin
            so_valid = 1'($urandom_range(1));
            so_data  = 1'($urandom_range(1));
            tick();
        end
        so_valid = 1'b0;
        checks++;
        if (oem_finish !== 1'b1 || wr_cnt - base !== 256) begin
            errors++;
            $display("FAIL zfill_done_hold: fin=%b writes=%0d, required 1 256", oem_finish, wr_cnt - base);
        end
    endtask

    task automatic test_partial();
        int base;
        logic [3:0] nib;
        apply_reset();
        base = wr_cnt;
        send_byte(8'hAB, 1'b1);
        nib = 4'hC;
        for (int i = 3; i >= 0; i--) begin
            so_valid = 1'b1;
            so_data  = nib[i];
            tick();
        end
        so_valid = 1'b0;
        tick();
        wait_finish(400);
        check_fill("partial", base, 8'hAB, 8'hC0);
    endtask

    task automatic test_mid_fill_reset();
        int base;
        apply_reset();
        base = wr_cnt;
        send_byte(8'h55, 1'b1);
        so_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (strb !== 8'h00 || oem_finish !== 1'b0) begin
            errors++;
            $display("FAIL midfill_stop: strb=%h fin=%b, required 00 0", strb, oem_finish);
        end
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (wr_cnt - base !== 7 || oem_finish !== 1'b0) begin
            errors++;
            $display("FAIL midfill_idle: writes=%0d fin=%b, required 7 0", wr_cnt - base, oem_finish);
        end
        send_byte(8'h77, 1'b0);
        checks++;
        if (strb !== 8'h01 || oem_addr !== 5'd0 || oem_dataout !== 8'h77) begin
            errors++;
            $display("FAIL midfill_restart: strb=%h addr=%0d data=%h, required 01 0 77", strb, oem_addr, oem_dataout);
        end
        so_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_mapping();
        test_zero_fill();
        test_partial();
        test_mid_fill_reset();
        checks++;
        if (multi_hot !== 0) begin
            errors++;
            $display("FAIL onehot_strobes: %0d cycles with multiple strobes, required 0", multi_hot);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
